// File: rtl/instr_decoder_pkg.sv
// rtl/instr_decoder_pkg.sv - Frost32 decoded-field bundle and instruction-group layouts
package PkgInstrDecoder;

  localparam int MSB_POS__INSTRUCTION = 31;

  typedef struct packed {
    logic [3:0]  group;
    logic [3:0]  ra_index;
    logic [3:0]  rb_index;
    logic [3:0]  rc_index;
    logic [3:0]  opcode;
    logic [15:0] imm_val;
  } PortOut_InstrDecoder;

  typedef struct packed {
    logic [3:0]  group;
    logic [3:0]  ra_index;
    logic [3:0]  rb_index;
    logic [3:0]  rc_index;
    logic [3:0]  opcode;
    logic [11:0] imm_val;
  } Iog0Instr;

  typedef struct packed {
    logic [3:0]  group;
    logic [3:0]  ra_index;
    logic [3:0]  rb_index;
    logic [3:0]  opcode;
    logic [15:0] imm_val;
  } Iog1Instr;

  typedef struct packed {
    logic [3:0]  group;
    logic [3:0]  ra_index;
    logic [3:0]  rb_index;
    logic [3:0]  rc_index;
    logic [3:0]  opcode;
    logic [11:0] reserved;
  } Iog2Instr;

  typedef Iog2Instr Iog3Instr;

endpackage

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - packing function and constants for the instruction encoder
package PkgInstrEncoder;
  import PkgInstrDecoder::*;

  localparam int ENC_BUF_DEPTH   = 2;
  localparam int ERR_COUNT_WIDTH = 8;
  localparam int PAYLOAD_WIDTH   = MSB_POS__INSTRUCTION + 2;

  typedef struct packed {
    logic [MSB_POS__INSTRUCTION:0] word;
    logic                          lossy;
    logic                          bad_group;
  } pack_result_t;

  function automatic pack_result_t pack_instr(input PortOut_InstrDecoder f);
    pack_result_t r;
    Iog0Instr     i0;
    Iog1Instr     i1;
    Iog2Instr     i2;
    r  = '0;
    i0 = '{group: f.group, ra_index: f.ra_index, rb_index: f.rb_index,
           rc_index: f.rc_index, opcode: f.opcode, imm_val: f.imm_val[11:0]};
    i1 = '{group: f.group, ra_index: f.ra_index, rb_index: f.rb_index,
           opcode: f.opcode, imm_val: f.imm_val};
    i2 = '{group: f.group, ra_index: f.ra_index, rb_index: f.rb_index,
           rc_index: f.rc_index, opcode: f.opcode, reserved: 12'h000};
    case (f.group)
      4'd0: begin
        r.word  = i0;
        r.lossy = |f.imm_val[15:12];
      end
      4'd1: begin
        r.word  = i1;
        r.lossy = |f.rc_index;
      end
      // groups 2 and 3 share one layout and carry no immediate
      4'd2, 4'd3: begin
        r.word  = i2;
        r.lossy = |f.imm_val;
      end
      default: r.bad_group = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_buf.sv
// rtl/instr_encoder_buf.sv - small registered FIFO holding packed words and their lossy flag
module instr_encoder_buf
  import PkgInstrEncoder::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [PAYLOAD_WIDTH-1:0] wr_data,
  input  logic                     rd_ready,
  output logic [PAYLOAD_WIDTH-1:0] rd_data,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(ENC_BUF_DEPTH);
  localparam int CNT_W = $clog2(ENC_BUF_DEPTH + 1);

  logic [PAYLOAD_WIDTH-1:0] mem [ENC_BUF_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     push;
  logic                     pop;

  assign full    = (count == CNT_W'(ENC_BUF_DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_valid && !full;
  assign pop     = rd_ready && !empty;
  // read straight from storage; a word pushed into an empty buffer shows up one cycle later
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENC_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded-field bundles into Frost32 words, filtering bad groups
module instr_encoder
  import PkgInstrDecoder::*;
  import PkgInstrEncoder::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  PortOut_InstrDecoder              in_fields,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MSB_POS__INSTRUCTION:0]    out_word,
  output logic                             out_lossy,
  output logic                             err_bad_group,
  output logic [ERR_COUNT_WIDTH-1:0]       err_count,
  input  logic                             clr_err
);

  pack_result_t             enc;
  logic                     accept;
  logic                     buf_full;
  logic                     buf_empty;
  logic [PAYLOAD_WIDTH-1:0] rd_data;

  always_comb enc = pack_instr(in_fields);

  assign accept    = in_valid && in_ready;
  assign in_ready  = !buf_full;
  assign out_valid = !buf_empty;
  assign out_word  = rd_data[PAYLOAD_WIDTH-1:1];
  assign out_lossy = rd_data[0];

  instr_encoder_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (accept && !enc.bad_group),
    .wr_data  ({enc.word, enc.lossy}),
    .rd_ready (out_ready),
    .rd_data  (rd_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bad_group <= 1'b0;
      err_count     <= '0;
    end else begin
      err_bad_group <= accept && enc.bad_group;
      // clear takes priority over a same-cycle increment
      if (clr_err)
        err_count <= '0;
      else if (accept && enc.bad_group && (err_count != '1))
        err_count <= err_count + ERR_COUNT_WIDTH'(1);
    end
  end

endmodule
